// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_pkg
// Purpose : Shared types and constants for the pipeline hazard controller.
//           state_t : trap sequencer states (RUN, HOLD, TRAP)
//           cause_t : latched trap cause (interrupt / undefined instruction)
//           c_defIntVector / c_defExcVector : default trap entry PCs
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } state_t;

  typedef enum logic {
    CAUSE_INT   = 1'b0,
    CAUSE_UNDEF = 1'b1
  } cause_t;

  localparam logic [31:0] c_defIntVector = 32'h8000_0004;
  localparam logic [31:0] c_defExcVector = 32'h8000_0008;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module  : hazard_fwd_select
// Purpose : Priority comparator choosing the youngest forwarding source whose
//           destination matches an EX source register.
// Ports   : iExAddr   - EX source register address
//           iSrcWrite - per-source write enable (index 0 youngest)
//           iSrcAddr  - per-source destination, source k at [k*ADDR_W +: ADDR_W]
//           oSel      - 0 = register file, k = source k-1
// Revision: 1.0 - initial release
// ============================================================================
module hazard_fwd_select #(
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic [ADDR_W-1:0]            iExAddr,
  input  logic [FWD_STAGES-1:0]        iSrcWrite,
  input  logic [FWD_STAGES*ADDR_W-1:0] iSrcAddr,
  output logic [FSEL_W-1:0]            oSel
);

  // Scan oldest to youngest so the lowest matching index is the last writer.
  // Register 0 is hard-wired zero and must never be forwarded.
  always_comb begin
    oSel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (iSrcWrite[k] &&
          (iSrcAddr[k*ADDR_W +: ADDR_W] != '0) &&
          (iSrcAddr[k*ADDR_W +: ADDR_W] == iExAddr)) begin
        oSel = FSEL_W'(k + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : Hazard, forwarding and trap-sequencing controller for the
//           five-stage pipeline. Drives the pipeline register enables/flushes.
// Ports   : clk, reset             - clock, async active-high reset
//           iInterrupt, IF_PC      - interrupt request, fetch PC (kernel bit)
//           ID_*                   - decode-stage instruction info
//           EX_*                   - execute-stage instruction info
//           SrcRegWrite/Addr       - forwarding sources (index 0 youngest)
//           iMemBusy               - data memory stall
//           oForwardA/B            - operand forwarding selects
//           oPCWrite, oIF_ID_Write - PC / IF-ID enables
//           oIF_ID_Flush, oID_EX_Flush, oPipeFreeze
//           oPCRedirect, oRedirectPC, oEPCWrite, oEPC - trap entry
//           oStallCycles           - saturating count of PC-stall cycles
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter int                FWD_STAGES = 2,
  parameter int                KERNEL_BIT = 31,
  parameter logic [DATA_W-1:0] INT_VECTOR = DATA_W'(c_defIntVector),
  parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(c_defExcVector),
  localparam int               FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iInterrupt,
  input  logic [DATA_W-1:0]            IF_PC,
  input  logic                         ID_Valid,
  input  logic [DATA_W-1:0]            ID_PC_plus_4,
  input  logic [ADDR_W-1:0]            ID_Rs,
  input  logic [ADDR_W-1:0]            ID_Rt,
  input  logic                         ID_UsesRs,
  input  logic                         ID_UsesRt,
  input  logic                         ID_Undefined,
  input  logic                         ID_Jump,
  input  logic [ADDR_W-1:0]            EX_Rs,
  input  logic [ADDR_W-1:0]            EX_Rt,
  input  logic                         EX_MemRead,
  input  logic [ADDR_W-1:0]            EX_RegWriteAddr,
  input  logic                         EX_BranchTaken,
  input  logic [FWD_STAGES-1:0]        SrcRegWrite,
  input  logic [FWD_STAGES*ADDR_W-1:0] SrcRegWriteAddr,
  input  logic                         iMemBusy,
  output logic [FSEL_W-1:0]            oForwardA,
  output logic [FSEL_W-1:0]            oForwardB,
  output logic                         oPCWrite,
  output logic                         oIF_ID_Write,
  output logic                         oIF_ID_Flush,
  output logic                         oID_EX_Flush,
  output logic                         oPipeFreeze,
  output logic                         oPCRedirect,
  output logic [DATA_W-1:0]            oRedirectPC,
  output logic                         oEPCWrite,
  output logic [DATA_W-1:0]            oEPC,
  output logic [31:0]                  oStallCycles
);

  state_t            r_state;
  state_t            w_nextState;
  cause_t            r_cause;
  logic [DATA_W-1:0] r_epc;
  logic [31:0]       r_stallCycles;
  logic              w_trapReq;
  logic              w_loadUse;
  logic              w_capture;
  logic              w_unusedPcBits;

  // Only the kernel-mode bit of the fetch PC matters here.
  assign w_unusedPcBits = ^IF_PC;

  hazard_fwd_select #(.ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES), .FSEL_W(FSEL_W)) u_fwdA (
    .iExAddr  (EX_Rs),
    .iSrcWrite(SrcRegWrite),
    .iSrcAddr (SrcRegWriteAddr),
    .oSel     (oForwardA)
  );

  hazard_fwd_select #(.ADDR_W(ADDR_W), .FWD_STAGES(FWD_STAGES), .FSEL_W(FSEL_W)) u_fwdB (
    .iExAddr  (EX_Rt),
    .iSrcWrite(SrcRegWrite),
    .iSrcAddr (SrcRegWriteAddr),
    .oSel     (oForwardB)
  );

  // Undefined opcodes trap in any mode; interrupts are masked in kernel mode.
  assign w_trapReq = ID_Valid & (ID_Undefined | (iInterrupt & ~IF_PC[KERNEL_BIT]));

  assign w_loadUse = EX_MemRead && (EX_RegWriteAddr != '0) &&
                     ((ID_UsesRs && (ID_Rs == EX_RegWriteAddr)) ||
                      (ID_UsesRt && (ID_Rt == EX_RegWriteAddr)));

  always_comb begin
    w_nextState  = r_state;
    w_capture    = 1'b0;
    oPCWrite     = 1'b1;
    oIF_ID_Write = 1'b1;
    oIF_ID_Flush = 1'b0;
    oID_EX_Flush = 1'b0;
    oPipeFreeze  = 1'b0;
    oPCRedirect  = 1'b0;
    oRedirectPC  = '0;
    oEPCWrite    = 1'b0;
    if (iMemBusy) begin
      // Whole pipeline frozen; sequencer holds its place.
      oPCWrite     = 1'b0;
      oIF_ID_Write = 1'b0;
      oPipeFreeze  = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (EX_BranchTaken) begin
            // Wrong-path ID instruction is squashed, so any trap it raised is dropped.
            oIF_ID_Flush = 1'b1;
            oID_EX_Flush = 1'b1;
          end else if (w_trapReq) begin
            oPCWrite     = 1'b0;
            oIF_ID_Write = 1'b0;
            oID_EX_Flush = 1'b1;
            w_capture    = 1'b1;
            w_nextState  = HOLD;
          end else if (w_loadUse) begin
            oPCWrite     = 1'b0;
            oIF_ID_Write = 1'b0;
            oID_EX_Flush = 1'b1;
          end else if (ID_Jump) begin
            oIF_ID_Flush = 1'b1;
          end
        end
        HOLD: begin
          oPCWrite     = 1'b0;
          oIF_ID_Write = 1'b0;
          oID_EX_Flush = 1'b1;
          w_nextState  = TRAP;
        end
        TRAP: begin
          oPCRedirect  = 1'b1;
          oRedirectPC  = (r_cause == CAUSE_UNDEF) ? EXC_VECTOR : INT_VECTOR;
          oIF_ID_Flush = 1'b1;
          oID_EX_Flush = 1'b1;
          oEPCWrite    = 1'b1;
          w_nextState  = RUN;
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_cause       <= CAUSE_INT;
      r_epc         <= '0;
      r_stallCycles <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_capture) begin
        r_cause <= ID_Undefined ? CAUSE_UNDEF : CAUSE_INT;
        r_epc   <= ID_PC_plus_4 - DATA_W'(4);
      end
      if (!oPCWrite && (r_stallCycles != 32'hFFFF_FFFF)) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
    end
  end

  assign oEPC         = r_epc;
  assign oStallCycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : Self-checking bench for pipeline_hazard_ctrl: directed scenarios
//           plus randomized cycles against a behavioural trap/hazard model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        iInterrupt, ID_Valid, ID_UsesRs, ID_UsesRt, ID_Undefined, ID_Jump;
  logic [31:0] IF_PC, ID_PC_plus_4;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RegWriteAddr;
  logic        EX_MemRead, EX_BranchTaken, iMemBusy;
  logic [1:0]  SrcRegWrite;
  logic [9:0]  SrcRegWriteAddr;
  logic [1:0]  oForwardA, oForwardB;
  logic        oPCWrite, oIF_ID_Write, oIF_ID_Flush, oID_EX_Flush, oPipeFreeze;
  logic        oPCRedirect, oEPCWrite;
  logic [31:0] oRedirectPC, oEPC, oStallCycles;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .iInterrupt(iInterrupt), .IF_PC(IF_PC),
    .ID_Valid(ID_Valid), .ID_PC_plus_4(ID_PC_plus_4), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Undefined(ID_Undefined),
    .ID_Jump(ID_Jump), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead),
    .EX_RegWriteAddr(EX_RegWriteAddr), .EX_BranchTaken(EX_BranchTaken),
    .SrcRegWrite(SrcRegWrite), .SrcRegWriteAddr(SrcRegWriteAddr), .iMemBusy(iMemBusy),
    .oForwardA(oForwardA), .oForwardB(oForwardB), .oPCWrite(oPCWrite),
    .oIF_ID_Write(oIF_ID_Write), .oIF_ID_Flush(oIF_ID_Flush), .oID_EX_Flush(oID_EX_Flush),
    .oPipeFreeze(oPipeFreeze), .oPCRedirect(oPCRedirect), .oRedirectPC(oRedirectPC),
    .oEPCWrite(oEPCWrite), .oEPC(oEPC), .oStallCycles(oStallCycles)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Trap progress: cycles of trap sequence still owed (0 = none pending).
  int          m_trapLeft;
  bit          m_undef;
  logic [31:0] m_epc;
  longint      m_stalls;
  bit          m_accept;
  logic        e_pcw, e_ifw, e_iff, e_ief, e_frz, e_red, e_epcw;
  logic [31:0] e_rpc;

  function automatic logic [1:0] refFwd(input logic [4:0] a);
    for (int k = 0; k < 2; k++)
      if (SrcRegWrite[k] && SrcRegWriteAddr[k*5 +: 5] != 5'd0 && SrcRegWriteAddr[k*5 +: 5] == a)
        return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_trapLeft = 0; m_undef = 0; m_epc = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    bit trap, lu;
    e_pcw = 1; e_ifw = 1; e_iff = 0; e_ief = 0; e_frz = 0; e_red = 0; e_epcw = 0;
    e_rpc = 0; m_accept = 0;
    trap = ID_Valid && (ID_Undefined || (iInterrupt && !IF_PC[31]));
    lu = EX_MemRead && EX_RegWriteAddr != 0 &&
         ((ID_UsesRs && ID_Rs == EX_RegWriteAddr) || (ID_UsesRt && ID_Rt == EX_RegWriteAddr));
    if (iMemBusy) begin
      e_pcw = 0; e_ifw = 0; e_frz = 1;
    end else if (m_trapLeft == 2) begin
      e_pcw = 0; e_ifw = 0; e_ief = 1;
    end else if (m_trapLeft == 1) begin
      e_red = 1; e_rpc = m_undef ? 32'h80000008 : 32'h80000004;
      e_iff = 1; e_ief = 1; e_epcw = 1;
    end else if (EX_BranchTaken) begin
      e_iff = 1; e_ief = 1;
    end else if (trap) begin
      e_pcw = 0; e_ifw = 0; e_ief = 1; m_accept = 1;
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_ief = 1;
    end else if (ID_Jump) begin
      e_iff = 1;
    end
  endtask

  task automatic model_tick();
    if (!e_pcw && m_stalls < 64'hFFFFFFFF) m_stalls++;
    if (!iMemBusy) begin
      if (m_trapLeft > 0) m_trapLeft--;
      else if (m_accept) begin
        m_trapLeft = 2; m_undef = ID_Undefined; m_epc = ID_PC_plus_4 - 32'd4;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    iInterrupt = 0; IF_PC = 0; ID_Valid = 0; ID_PC_plus_4 = 0; ID_Rs = 0; ID_Rt = 0;
    ID_UsesRs = 0; ID_UsesRt = 0; ID_Undefined = 0; ID_Jump = 0; EX_Rs = 0; EX_Rt = 0;
    EX_MemRead = 0; EX_RegWriteAddr = 0; EX_BranchTaken = 0; SrcRegWrite = 0;
    SrcRegWriteAddr = 0; iMemBusy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (oPCWrite !== 1'b1 || oIF_ID_Write !== 1'b1) begin failures++;
      $display("FAIL reset_enables: got %b%b expected 11", oPCWrite, oIF_ID_Write); end
    checks++; if ({oIF_ID_Flush, oID_EX_Flush, oPipeFreeze, oPCRedirect, oEPCWrite} !== 5'b0) begin failures++;
      $display("FAIL reset_flags: got %b expected 00000", {oIF_ID_Flush, oID_EX_Flush, oPipeFreeze, oPCRedirect, oEPCWrite}); end
    checks++; if (oStallCycles !== 32'd0 || oEPC !== 32'd0 || oRedirectPC !== 32'd0) begin failures++;
      $display("FAIL reset_regs: got stall=%0d epc=%h rpc=%h expected 0", oStallCycles, oEPC, oRedirectPC); end
  endtask

  task automatic test_forward();
    do_reset();
    SrcRegWrite = 2'b11; SrcRegWriteAddr = {5'd8, 5'd8}; EX_Rs = 5'd8; EX_Rt = 5'd3; #1;
    checks++; if (oForwardA !== 2'd1) begin failures++; $display("FAIL fwd_youngest: got %0d expected 1", oForwardA); end
    checks++; if (oForwardB !== 2'd0) begin failures++; $display("FAIL fwd_nomatch: got %0d expected 0", oForwardB); end
    SrcRegWrite = 2'b01; SrcRegWriteAddr = {5'd7, 5'd0}; EX_Rs = 5'd0; EX_Rt = 5'd7; #1;
    checks++; if (oForwardA !== 2'd0) begin failures++; $display("FAIL fwd_zero_reg: got %0d expected 0", oForwardA); end
    checks++; if (oForwardB !== 2'd0) begin failures++; $display("FAIL fwd_wr_disabled: got %0d expected 0", oForwardB); end
    SrcRegWrite = 2'b10; EX_Rt = 5'd7; #1;
    checks++; if (oForwardB !== 2'd2) begin failures++; $display("FAIL fwd_src1: got %0d expected 2", oForwardB); end
  endtask

  task automatic test_load_use();
    do_reset();
    EX_MemRead = 1; EX_RegWriteAddr = 5'd9; ID_Valid = 1; ID_Rt = 5'd9; ID_UsesRt = 1; #1;
    checks++; if (oPCWrite !== 1'b0 || oIF_ID_Write !== 1'b0 || oID_EX_Flush !== 1'b1 || oIF_ID_Flush !== 1'b0) begin failures++;
      $display("FAIL loaduse_stall: got pcw=%b ifw=%b ief=%b iff=%b expected 0010", oPCWrite, oIF_ID_Write, oID_EX_Flush, oIF_ID_Flush); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (oStallCycles !== 32'd1 || oPCWrite !== 1'b1) begin failures++;
      $display("FAIL loaduse_count: got stall=%0d pcw=%b expected 1 1", oStallCycles, oPCWrite); end
  endtask

  task automatic test_interrupt();
    do_reset();
    iInterrupt = 1; IF_PC = 32'h40; ID_PC_plus_4 = 32'h3C; ID_Valid = 1; ID_Jump = 1; #1;
    checks++; if (oPCWrite !== 1'b0 || oID_EX_Flush !== 1'b1 || oIF_ID_Flush !== 1'b0) begin failures++;
      $display("FAIL int_accept: got pcw=%b ief=%b iff=%b expected 010", oPCWrite, oID_EX_Flush, oIF_ID_Flush); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (oPCWrite !== 1'b0 || oID_EX_Flush !== 1'b1 || oPCRedirect !== 1'b0) begin failures++;
      $display("FAIL int_hold: got pcw=%b ief=%b red=%b expected 010", oPCWrite, oID_EX_Flush, oPCRedirect); end
    next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b1 || oRedirectPC !== 32'h80000004 || oEPCWrite !== 1'b1 || oIF_ID_Flush !== 1'b1) begin failures++;
      $display("FAIL int_trap: got red=%b rpc=%h epcw=%b iff=%b expected 1 80000004 1 1", oPCRedirect, oRedirectPC, oEPCWrite, oIF_ID_Flush); end
    checks++; if (oEPC !== 32'h38 || oStallCycles !== 32'd2) begin failures++;
      $display("FAIL int_epc: got epc=%h stall=%0d expected 00000038 2", oEPC, oStallCycles); end
    next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b0 || oPCWrite !== 1'b1 || oEPCWrite !== 1'b0) begin failures++;
      $display("FAIL int_resume: got red=%b pcw=%b epcw=%b expected 010", oPCRedirect, oPCWrite, oEPCWrite); end
  endtask

  task automatic test_kernel();
    do_reset();
    IF_PC = 32'h80000100; ID_Valid = 1; ID_Undefined = 1; ID_PC_plus_4 = 32'h800000F8; #1;
    next_cycle(); clear_inputs(); next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b1 || oRedirectPC !== 32'h80000008 || oEPC !== 32'h800000F4) begin failures++;
      $display("FAIL undef_kernel: got red=%b rpc=%h epc=%h expected 1 80000008 800000f4", oPCRedirect, oRedirectPC, oEPC); end
    do_reset();
    IF_PC = 32'h80000100; ID_Valid = 1; iInterrupt = 1; ID_PC_plus_4 = 32'h800000F8; #1;
    checks++; if (oPCWrite !== 1'b1 || oID_EX_Flush !== 1'b0) begin failures++;
      $display("FAIL int_masked: got pcw=%b ief=%b expected 1 0", oPCWrite, oID_EX_Flush); end
    next_cycle(); next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b0 || oStallCycles !== 32'd0) begin failures++;
      $display("FAIL int_masked_seq: got red=%b stall=%0d expected 0 0", oPCRedirect, oStallCycles); end
  endtask

  task automatic test_membusy_hold();
    do_reset();
    ID_Valid = 1; iInterrupt = 1; ID_PC_plus_4 = 32'h104; #1;
    next_cycle(); clear_inputs(); iMemBusy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (oPipeFreeze !== 1'b1 || oID_EX_Flush !== 1'b0 || oIF_ID_Flush !== 1'b0 || oPCRedirect !== 1'b0 || oPCWrite !== 1'b0) begin failures++;
        $display("FAIL busy_hold[%0d]: got frz=%b ief=%b iff=%b red=%b pcw=%b expected 10000", i, oPipeFreeze, oID_EX_Flush, oIF_ID_Flush, oPCRedirect, oPCWrite); end
      next_cycle();
    end
    iMemBusy = 0; #1;
    checks++; if (oID_EX_Flush !== 1'b1 || oPCRedirect !== 1'b0 || oPipeFreeze !== 1'b0) begin failures++;
      $display("FAIL busy_hold_resume: got ief=%b red=%b frz=%b expected 100", oID_EX_Flush, oPCRedirect, oPipeFreeze); end
    next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b1 || oEPC !== 32'h100 || oStallCycles !== 32'd5) begin failures++;
      $display("FAIL busy_trap: got red=%b epc=%h stall=%0d expected 1 00000100 5", oPCRedirect, oEPC, oStallCycles); end
  endtask

  task automatic test_branch_vs_trap();
    do_reset();
    EX_BranchTaken = 1; ID_Valid = 1; ID_Undefined = 1; ID_PC_plus_4 = 32'h20; #1;
    checks++; if (oIF_ID_Flush !== 1'b1 || oID_EX_Flush !== 1'b1 || oPCWrite !== 1'b1) begin failures++;
      $display("FAIL branch_wins: got iff=%b ief=%b pcw=%b expected 111", oIF_ID_Flush, oID_EX_Flush, oPCWrite); end
    next_cycle(); clear_inputs(); #1;
    checks++; if (oPCWrite !== 1'b1 || oID_EX_Flush !== 1'b0) begin failures++;
      $display("FAIL branch_no_hold: got pcw=%b ief=%b expected 1 0", oPCWrite, oID_EX_Flush); end
    next_cycle(); #1;
    checks++; if (oPCRedirect !== 1'b0) begin failures++; $display("FAIL branch_no_trap: got red=%b expected 0", oPCRedirect); end
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    ID_Valid = 1; ID_Undefined = 1; ID_PC_plus_4 = 32'h50; #1;
    next_cycle(); clear_inputs();
    reset = 1; #1;
    checks++; if (oPCRedirect !== 1'b0 || oPCWrite !== 1'b1 || oEPC !== 32'd0) begin failures++;
      $display("FAIL rst_mid_trap: got red=%b pcw=%b epc=%h expected 0 1 0", oPCRedirect, oPCWrite, oEPC); end
    next_cycle(); reset = 0; model_reset();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (oPCRedirect !== 1'b0 || oPCWrite !== 1'b1) begin failures++;
        $display("FAIL rst_no_redirect[%0d]: got red=%b pcw=%b expected 0 1", i, oPCRedirect, oPCWrite); end
      next_cycle();
    end
  endtask

  task automatic test_random(input int n);
    do_reset();
    for (int c = 0; c < n; c++) begin
      iInterrupt = ($urandom_range(3) == 0); IF_PC = $urandom; ID_Valid = ($urandom_range(3) != 0);
      ID_PC_plus_4 = $urandom; ID_Rs = 5'($urandom_range(3)); ID_Rt = 5'($urandom_range(3));
      ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom); ID_Undefined = ($urandom_range(7) == 0);
      ID_Jump = ($urandom_range(5) == 0); EX_Rs = 5'($urandom_range(3)); EX_Rt = 5'($urandom_range(3));
      EX_MemRead = ($urandom_range(2) == 0); EX_RegWriteAddr = 5'($urandom_range(3));
      EX_BranchTaken = ($urandom_range(5) == 0); SrcRegWrite = 2'($urandom);
      SrcRegWriteAddr = {5'($urandom_range(3)), 5'($urandom_range(3))}; iMemBusy = ($urandom_range(4) == 0);
      model_eval();
      @(negedge clk);
      checks++; if (oForwardA !== refFwd(EX_Rs) || oForwardB !== refFwd(EX_Rt)) begin failures++;
        $display("FAIL rnd_fwd c%0d: got %0d/%0d expected %0d/%0d", c, oForwardA, oForwardB, refFwd(EX_Rs), refFwd(EX_Rt)); end
      checks++; if ({oPCWrite, oIF_ID_Write, oIF_ID_Flush, oID_EX_Flush, oPipeFreeze, oPCRedirect, oEPCWrite} !==
                    {e_pcw, e_ifw, e_iff, e_ief, e_frz, e_red, e_epcw}) begin failures++;
        $display("FAIL rnd_ctrl c%0d: got %b expected %b", c, {oPCWrite, oIF_ID_Write, oIF_ID_Flush, oID_EX_Flush, oPipeFreeze, oPCRedirect, oEPCWrite},
                 {e_pcw, e_ifw, e_iff, e_ief, e_frz, e_red, e_epcw}); end
      checks++; if (oRedirectPC !== e_rpc || oEPC !== m_epc || oStallCycles !== 32'(m_stalls)) begin failures++;
        $display("FAIL rnd_regs c%0d: got rpc=%h epc=%h stall=%0d expected %h %h %0d", c, oRedirectPC, oEPC, oStallCycles, e_rpc, m_epc, m_stalls); end
      @(posedge clk);
      model_tick();
      #1;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_forward();
    test_load_use();
    test_interrupt();
    test_kernel();
    test_membusy_hold();
    test_branch_vs_trap();
    test_reset_mid_trap();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard, forwarding and trap-sequencing controller for the five-stage pipeline core. It generalises the fixed two-source MEM/WB forwarding to N sources, adds load-use stall, branch/jump flush, memory-busy freeze, and a sequenced trap entry for interrupts and undefined instructions with EPC capture. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush inputs.

## Interface
- ADDR_W, 5, register-address width
- DATA_W, 32, datapath/PC width
- FWD_STAGES, 2, number of forwarding sources; index 0 is the youngest (EX/MEM)
- KERNEL_BIT, 31, PC bit marking kernel mode
- INT_VECTOR, 32'h80000004, interrupt entry PC
- EXC_VECTOR, 32'h80000008, undefined-instruction entry PC
- FSEL_W = $clog2(FWD_STAGES+1), derived, not overridable

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- iInterrupt  in  1  level interrupt request
- IF_PC  in  DATA_W  current fetch PC
- ID_Valid  in  1  ID holds a real instruction (not a bubble)
- ID_PC_plus_4  in  DATA_W  PC+4 of the ID instruction
- ID_Rs, ID_Rt  in  ADDR_W  ID source registers
- ID_UsesRs, ID_UsesRt  in  1  ID instruction reads that source
- ID_Undefined  in  1  decoder flagged an undefined opcode/funct
- ID_Jump  in  1  j/jal/jr/jalr resolved in ID
- EX_Rs, EX_Rt  in  ADDR_W  EX source registers
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWriteAddr  in  ADDR_W  EX destination register
- EX_BranchTaken  in  1  branch resolved taken in EX
- SrcRegWrite  in  FWD_STAGES  per-source write enable
- SrcRegWriteAddr  in  FWD_STAGES*ADDR_W  per-source destination, source k at [k*ADDR_W +: ADDR_W]
- iMemBusy  in  1  data memory not ready this cycle
- oForwardA, oForwardB  out  FSEL_W  0 = register file, k = source k-1
- oPCWrite, oIF_ID_Write  out  1  PC / IF-ID register enable
- oIF_ID_Flush, oID_EX_Flush  out  1  insert bubble
- oPipeFreeze  out  1  hold EX/MEM and MEM/WB
- oPCRedirect  out  1  load oRedirectPC into PC
- oRedirectPC  out  DATA_W  trap vector
- oEPCWrite  out  1  write oEPC into $26
- oEPC  out  DATA_W  captured exception PC
- oStallCycles  out  32  saturating count of cycles with oPCWrite=0

## Operation
- Forwarding (combinational): lowest index k with SrcRegWrite[k]=1, address ≠ 0 and address equal to EX_Rs (A) / EX_Rt (B) wins, giving select k+1; otherwise 0.
- FSM states: RUN, HOLD, TRAP.
- iMemBusy=1 in any state: state held, oPCWrite=oIF_ID_Write=0, oPipeFreeze=1, all flushes/redirect/EPCWrite 0.
- RUN, iMemBusy=0, priority order:
  1. EX_BranchTaken: oIF_ID_Flush=oID_EX_Flush=1; traps deferred.
  2. Trap request, which is ID_Valid & (ID_Undefined | (iInterrupt & ~IF_PC[KERNEL_BIT])): latch cause (undefined beats interrupt) and EPC = ID_PC_plus_4-4. oPCWrite=oIF_ID_Write=0, oID_EX_Flush=1. Go to HOLD.
  3. Load-use, where EX_MemRead, EX_RegWriteAddr≠0 and it matches a used ID source: oPCWrite=oIF_ID_Write=0, oID_EX_Flush=1.
  4. ID_Jump: oIF_ID_Flush=1.
  5. Otherwise all enables 1 and no flushes.
- HOLD: oPCWrite=oIF_ID_Write=0, oID_EX_Flush=1. Go to TRAP.
- TRAP: oPCRedirect=1, oRedirectPC = vector of latched cause, oIF_ID_Flush=oID_EX_Flush=1, oEPCWrite=1. Go to RUN.
- Undefined instructions trap regardless of kernel bit. Interrupts are masked in kernel.
- oStallCycles increments on each cycle with oPCWrite=0 and saturates at 32'hFFFFFFFF.

## Timing
- Reset: state RUN, latched cause/EPC 0, oStallCycles 0. In RUN with idle inputs, outputs are oPCWrite=oIF_ID_Write=1 and all others 0.
- Forward selects and RUN stall/flush outputs are combinational, same cycle.
- Trap accepted in cycle T: HOLD at T+1, TRAP (redirect + EPC write) at T+2, first vector fetch at T+3. Each iMemBusy cycle adds one cycle.
- Reset asserted mid-trap: returns to RUN immediately, and no redirect is issued.
- Branch in EX and trap request in the same cycle: branch wins, and the trap is re-evaluated on the refetched instruction.

## Structure
- Package pipeline_pkg: state enum {RUN, HOLD, TRAP}, cause enum {CAUSE_INT, CAUSE_UNDEF}, default vector constants.
- Sub-module hazard_fwd_select (parametrised priority comparator), instantiated twice for A and B.

## Test plan
- Forwarding: sources 0 and 1 both write $8, EX_Rs=8 -> oForwardA=1. Source 0 addr 0 only -> oForwardA=0.
- Load-use: EX lw $9, ID add using $9 -> one cycle with oPCWrite=0 and oID_EX_Flush=1, oStallCycles=1.
- Interrupt: iInterrupt=1, IF_PC=0x00000040, ID_PC_plus_4=0x0000003C -> at T+2 oPCRedirect=1, oRedirectPC=0x80000004, oEPC=0x00000038.
- Undefined instruction with IF_PC[31]=1 -> traps to 0x80000008. Interrupt with IF_PC[31]=1 -> no trap.
- iMemBusy high for 3 cycles during HOLD -> TRAP delayed 3 cycles, no flushes while busy, oStallCycles +3.
- EX_BranchTaken and ID_Undefined together -> flush only, no HOLD entry.
